// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: banked palette lookup with frame-driven bank animation.
// Define SPRITE_PALETTE_FADE_EN to add the fade-out/fade-in stage on the color outputs.
module sprite_palette_bank #(
   parameter int  INDEX_W   = 4,
   parameter int  NUM_BANKS = 4,
   parameter int  COLOR_W   = 4,
   parameter int  ANIM_W    = 4,
   localparam int BANK_W    = $clog2(NUM_BANKS),
   localparam int RGB_W     = 3 * COLOR_W
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               pix_valid_i,
   input  logic [INDEX_W-1:0] index_i,
   input  logic [BANK_W-1:0]  bank_sel_i,
   input  logic               frame_tick_i,
   input  logic               anim_en_i,
   input  logic [ANIM_W-1:0]  anim_period_i,
   input  logic               wr_en_i,
   input  logic [BANK_W-1:0]  wr_bank_i,
   input  logic [INDEX_W-1:0] wr_index_i,
   input  logic [RGB_W-1:0]   wr_data_i,
   input  logic               fade_start_i,
   output logic [COLOR_W-1:0] red_o,
   output logic [COLOR_W-1:0] green_o,
   output logic [COLOR_W-1:0] blue_o,
   output logic               out_valid_o,
   output logic               transparent_o,
   output logic               fade_busy_o
);
   localparam int DEPTH = 2 ** INDEX_W;
   localparam logic [COLOR_W-1:0] CMAX = '1;

   logic [RGB_W-1:0]   pal_q [NUM_BANKS][DEPTH];
   logic [RGB_W-1:0]   rgb_q, rd;
   logic               valid_q, trans_q;
   logic [BANK_W-1:0]  ofs_q, ofs_d, eff_bank;
   logic [ANIM_W-1:0]  cnt_q, cnt_d, per_m1;
   logic [COLOR_W-1:0] level;
   logic               step;

   function automatic logic [COLOR_W-1:0] gray(input int i);
      return COLOR_W'(i >> (INDEX_W - COLOR_W));
   endfunction

   function automatic logic [COLOR_W-1:0] fade(input logic [COLOR_W-1:0] c, input logic [COLOR_W-1:0] lv);
      logic [COLOR_W-1:0] dec;
      dec = CMAX - lv;
      return (c > dec) ? c - dec : '0;
   endfunction

   // Non-blocking update gives read-before-write on a same-cycle hit
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         for (int b = 0; b < NUM_BANKS; b++)
            for (int i = 0; i < DEPTH; i++)
               pal_q[b][i] <= {3{gray(i)}};
      end else if (wr_en_i) begin
         pal_q[wr_bank_i][wr_index_i] <= wr_data_i;
      end

   assign eff_bank = bank_sel_i + ofs_q;
   assign rd       = pal_q[eff_bank][index_i];

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         valid_q <= 1'b0;
         trans_q <= 1'b0;
         rgb_q   <= '0;
      end else begin
         valid_q <= pix_valid_i;
         if (pix_valid_i) begin
            trans_q <= (index_i == '0);
            rgb_q   <= {fade(rd[RGB_W-1 -: COLOR_W], level), fade(rd[2*COLOR_W-1 -: COLOR_W], level),
                        fade(rd[COLOR_W-1:0], level)};
         end
      end

   // A period of 0 behaves like 1: every frame advances the bank
   always_comb begin
      per_m1 = (anim_period_i == '0) ? '0 : anim_period_i - 1'b1;
      step   = frame_tick_i && (cnt_q >= per_m1);
      cnt_d  = !anim_en_i ? '0 : !frame_tick_i ? cnt_q : step ? '0 : ANIM_W'(cnt_q + 1'b1);
      ofs_d  = !anim_en_i ? '0 : step ? BANK_W'(ofs_q + 1'b1) : ofs_q;
   end

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         cnt_q <= '0;
         ofs_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         ofs_q <= ofs_d;
      end

`ifdef SPRITE_PALETTE_FADE_EN
   typedef enum logic [1:0] {IDLE, FADE_OUT, DARK, FADE_IN} state_t;
   state_t             state_q, state_d;
   logic [COLOR_W-1:0] level_q, level_d;

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state_q <= IDLE;
         level_q <= CMAX;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
      end

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      case (state_q)
         IDLE:     if (fade_start_i) state_d = FADE_OUT;
         FADE_OUT: if (frame_tick_i) begin
            level_d = level_q - 1'b1;
            if (level_q == COLOR_W'(1)) state_d = DARK;
         end
         DARK:     if (fade_start_i) state_d = FADE_IN;
         default:  if (frame_tick_i) begin
            level_d = level_q + 1'b1;
            if (level_q == CMAX - 1'b1) state_d = IDLE;
         end
      endcase
   end

   assign level       = level_q;
   assign fade_busy_o = (state_q != IDLE);
`else
   logic unused_fade;
   assign unused_fade = fade_start_i;
   assign level       = CMAX;
   assign fade_busy_o = 1'b0;
`endif

   assign red_o         = rgb_q[RGB_W-1 -: COLOR_W];
   assign green_o       = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign blue_o        = rgb_q[COLOR_W-1:0];
   assign out_valid_o   = valid_q;
   assign transparent_o = trans_q;
endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb_sprite_palette_bank: directed vectors against a frame-count palette model.
// Fade expectations are enabled along with SPRITE_PALETTE_FADE_EN.
module tb_sprite_palette_bank;
   localparam int NB = 4, CMAX = 15;

   logic        clk = 1'b0, rst = 1'b1;
   logic        pix_valid = 0, frame_tick = 0, anim_en = 0, wr_en = 0, fade_start = 0;
   logic [3:0]  index = 0, anim_period = 0, wr_index = 0;
   logic [1:0]  bank_sel = 0, wr_bank = 0;
   logic [11:0] wr_data = 0;
   logic [3:0]  red, green, blue;
   logic        out_valid, transparent, fade_busy;

   int vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   sprite_palette_bank dut (
      .clk_i(clk), .reset_i(rst), .pix_valid_i(pix_valid), .index_i(index), .bank_sel_i(bank_sel),
      .frame_tick_i(frame_tick), .anim_en_i(anim_en), .anim_period_i(anim_period),
      .wr_en_i(wr_en), .wr_bank_i(wr_bank), .wr_index_i(wr_index), .wr_data_i(wr_data),
      .fade_start_i(fade_start), .red_o(red), .green_o(green), .blue_o(blue),
      .out_valid_o(out_valid), .transparent_o(transparent), .fade_busy_o(fade_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: palette array, bank offset derived from frames counted since anim_en rose
   logic [11:0] pal [NB][16];
   logic [11:0] exp_rgb, c;
   bit          exp_v, exp_t;
   int          anim_ticks, level, fstate, per, eff;

   function automatic logic [3:0] fd(input logic [3:0] ch, input int lv);
      return (int'(ch) > CMAX - lv) ? 4'(int'(ch) - (CMAX - lv)) : 4'd0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NB; b++)
            for (int i = 0; i < 16; i++) pal[b][i] = {3{4'(i)}};
         anim_ticks = 0; level = CMAX; fstate = 0;
         exp_v = 0; exp_t = 0; exp_rgb = 0;
      end else begin
         per = (anim_period == 0) ? 1 : int'(anim_period);
         eff = (int'(bank_sel) + (anim_ticks / per) % NB) % NB;
         exp_v = pix_valid;
         if (pix_valid) begin
            c = pal[eff][index];
            exp_rgb = {fd(c[11:8], level), fd(c[7:4], level), fd(c[3:0], level)};
            exp_t = (index == 0);
         end
         if (wr_en) pal[wr_bank][wr_index] = wr_data;
         anim_ticks = !anim_en ? 0 : anim_ticks + int'(frame_tick);
`ifdef SPRITE_PALETTE_FADE_EN
         if (fstate == 0 && fade_start) fstate = 1;
         else if (fstate == 1 && frame_tick) begin level--; if (level == 0) fstate = 2; end
         else if (fstate == 2 && fade_start) fstate = 3;
         else if (fstate == 3 && frame_tick) begin level++; if (level == CMAX) fstate = 0; end
`endif
      end
   end

   always @(negedge clk)
      if (!rst) begin
         check("valid", out_valid, exp_v);
         check("rgb", {red, green, blue}, exp_rgb);
         check("transparent", transparent, exp_t);
         check("fade_busy", fade_busy, fstate != 0);
      end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         frame_tick = 1; step(); frame_tick = 0;
      end
   endtask

   task automatic look(input string name, input logic [11:0] e);
      step();
      @(negedge clk);
      check(name, {red, green, blue}, e);
   endtask

   initial begin
      logic [3:0] anim_red [5];
      anim_red = '{4'hB, 4'hB, 4'h8, 4'h8, 4'h9};
      step(2);
      rst = 0;
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_rgb", {red, green, blue}, 0);
      check("rst_transp", transparent, 0);
      check("rst_busy", fade_busy, 0);

      pix_valid = 1; index = 4'hA;
      look("gray_A", 12'hAAA);
      check("valid_A", out_valid, 1);
      check("transp_A", transparent, 0);
      index = 0;
      look("gray_0", 12'h000);
      check("transp_0", transparent, 1);
      index = 7;
      look("gray_7", 12'h777);
      pix_valid = 0;
      look("held_7", 12'h777);
      check("valid_drop", out_valid, 0);

      pix_valid = 1; bank_sel = 2; index = 5;
      wr_en = 1; wr_bank = 2; wr_index = 5; wr_data = 12'hF0D;
      look("rbw_old", 12'h555);
      wr_en = 0;
      look("rbw_new", 12'hF0D);

      for (int b = 0; b < NB; b++) begin
         wr_en = 1; wr_bank = 2'(b); wr_index = 1; wr_data = {4'(b + 8), 4'hE, 4'h1};
         step();
      end
      wr_en = 0;
      bank_sel = 3; index = 1; anim_period = 2; anim_en = 1;
      look("anim_0", {anim_red[0], 8'hE1});
      for (int k = 1; k < 5; k++) begin
         tick();
         look($sformatf("anim_%0d", k), {anim_red[k], 8'hE1});
      end
      anim_en = 0;
      step();
      look("anim_clear", 12'hBE1);
      bank_sel = 0; anim_period = 0; anim_en = 1;
      step();
      tick();
      look("period0_1", 12'h9E1);
      tick();
      look("period0_2", 12'hAE1);
      anim_en = 0;
      step(2);

      bank_sel = 2; index = 5;
`ifdef SPRITE_PALETTE_FADE_EN
      fade_start = 1; frame_tick = 1;
      step();
      fade_start = 0; frame_tick = 0;
      look("fade_nodec", 12'hF0D);
      check("fade_busy_on", fade_busy, 1);
      tick(3);
      look("fade_lvl12", 12'hC0A);
      tick(12);
      look("fade_dark", 12'h000);
      check("dark_busy", fade_busy, 1);
      fade_start = 1; step(); fade_start = 0;
      tick(15);
      look("fade_back", 12'hF0D);
      check("idle_busy", fade_busy, 0);
      fade_start = 1; step(); fade_start = 0;
      tick(8);
      look("fade_lvl7", 12'h705);
`else
      fade_start = 1; step(); fade_start = 0;
      tick(3);
      look("nofade_rgb", 12'hF0D);
      check("nofade_busy", fade_busy, 0);
`endif
      wr_en = 1; wr_bank = 0; wr_index = 3; wr_data = 12'h123;
      #1 rst = 1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_busy", fade_busy, 0);
      check("arst_rgb", {red, green, blue}, 0);
      step();
      rst = 0; wr_en = 0;
      look("arst_gray5", 12'h555);
      index = 4'hF;
      look("arst_lvl15", 12'hFFF);
      bank_sel = 0; index = 3;
      look("arst_nowrite", 12'h333);
      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sprite_palette_bank.md
SPRITE_PALETTE_BANK -- requirements
Module: sprite_palette_bank

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, pixel index width; palette depth is 2**INDEX_W.
REQ-002 SHALL have parameter NUM_BANKS, default 4, number of selectable palettes; power of two, 2..16.
REQ-003 SHALL have parameter COLOR_W, default 4, per-channel color width; COLOR_W <= INDEX_W.
REQ-004 SHALL have parameter ANIM_W, default 4, width of the animation period field.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pix_valid  in  1  lookup request this cycle.
REQ-008 index  in  INDEX_W  pixel color index.
REQ-009 bank_sel  in  clog2(NUM_BANKS)  base palette bank.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame.
REQ-011 anim_en  in  1  enable bank cycling.
REQ-012 anim_period  in  ANIM_W  frames per bank step; 0 is treated as 1.
REQ-013 wr_en, wr_bank, wr_index, wr_data  in  1/clog2(NUM_BANKS)/INDEX_W/3*COLOR_W  palette entry write; wr_data = {r,g,b}.
REQ-014 fade_start  in  1  fade request pulse.
REQ-015 red, green, blue  out  COLOR_W each  looked-up color.
REQ-016 out_valid  out  1  red/green/blue/transparent are valid.
REQ-017 transparent  out  1  looked-up index was 0.
REQ-018 fade_busy  out  1  fade in progress.

Function
REQ-019 Lookup SHALL have 1-cycle latency: pix_valid/index at edge N yield out_valid=1 plus color after edge N+1; out_valid=0 the cycle after pix_valid=0, with color held.
REQ-020 Effective bank SHALL be (bank_sel + anim_ofs) mod NUM_BANKS, sampled with index.
REQ-021 anim_ofs SHALL increment (wrapping at NUM_BANKS) after every max(anim_period,1) frame_tick pulses while anim_en=1; anim_en=0 clears anim_ofs and the frame counter on the next edge.
REQ-022 Write SHALL update entry [wr_bank][wr_index] at the edge wr_en=1; same-cycle read of that entry SHALL return the old value (read-before-write).
REQ-023 transparent SHALL equal (sampled index == 0) regardless of palette content.
REQ-024 Outputs SHALL pass through the fade stage: channel = sat0(c - (CMAX - level)), CMAX = 2**COLOR_W-1; level = CMAX when fade inactive.
REQ-025 Fade FSM states IDLE, FADE_OUT, DARK, FADE_IN: fade_start in IDLE -> FADE_OUT; level decrements by 1 per frame_tick; level reaching 0 -> DARK; fade_start in DARK -> FADE_IN; level increments by 1 per frame_tick; level reaching CMAX -> IDLE.
REQ-026 fade_start in FADE_OUT or FADE_IN SHALL be ignored; fade_busy=1 in FADE_OUT, DARK, FADE_IN.
REQ-027 frame_tick coincident with fade_start in IDLE SHALL enter FADE_OUT with no level decrement that cycle.

Reset
REQ-028 Reset SHALL force out_valid=0, transparent=0, red/green/blue=0, anim_ofs=0, frame counter=0, FSM=IDLE, level=CMAX, fade_busy=0.
REQ-029 Reset SHALL load every bank entry i with grayscale: each channel = i[INDEX_W-1 -: COLOR_W].
REQ-030 Reset asserted mid-fade or mid-write SHALL take effect immediately; the in-flight write is discarded.

Configuration
REQ-031 Macro SPRITE_PALETTE_FADE_EN defined: fade FSM of REQ-024..027 present.
REQ-032 Macro SPRITE_PALETTE_FADE_EN undefined: no FSM, level constant CMAX, fade_start ignored, fade_busy tied 0; all other behaviour unchanged.

Verification
REQ-033 Post-reset, defaults: pix_valid=1, index=4'hA, bank_sel=0 -> next cycle out_valid=1, rgb=A,A,A, transparent=0; index=0 -> rgb=0,0,0, transparent=1.
REQ-034 Write bank 2 idx 5 = 12'hF0D, read same cycle -> 5,5,5; read next cycle -> F,0,D.
REQ-035 anim_en=1, anim_period=2, bank_sel=3, NUM_BANKS=4 -> effective bank 3,3,0,0,1 across frame_ticks 0..4.
REQ-036 FADE_EN: entry F,0,D, fade_start then 3 frame_ticks -> level 12, output C,0,A; 15 ticks -> DARK, 0,0,0, fade_busy=1; fade_start + 15 ticks -> IDLE, F,0,D, fade_busy=0.
REQ-037 Reset asserted during FADE_OUT at level 7 -> immediately out_valid=0, fade_busy=0, level=15, palette grayscale.
